sdiv8: RTL and testbench
========================

Name: sdiv8

Overview:
- Sequential unsigned shift-subtract (restoring) divider.
- Inverse of the team's 8x8 shift-add multiplier: takes a 2*WIDTH-bit dividend (e.g. a product) and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Handshake is start/busy/done. Sits beside the multiplier datapath, and a product q feeds dividend directly.

Parameters:
WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; sampled only in IDLE
dividend  input  2*WIDTH  unsigned dividend; captured on accepted start
divisor  input  WIDTH  unsigned divisor; captured on accepted start
busy  output  1  high in RUN state
done  output  1  one-cycle pulse, high in DONE state
ovf  output  1  result invalid (divide-by-zero or quotient overflow); valid with done, held until next accepted start
quotient  output  WIDTH  result, held until next accepted start
remainder  output  WIDTH  result, held until next accepted start

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, ovf=0, quotient=0, remainder=0, internal regs and counter cleared. A reset mid-operation aborts the divide with no done pulse.
- States: IDLE, RUN, DONE. done is high only in DONE; busy is high only in RUN.
- IDLE, start=1 at edge k:
  - Capture divisor D.
  - Overflow check: if D==0 or dividend[2W-1:W] >= D, then ovf=1, quotient=0, remainder=0, and next state is DONE. done is high in cycle k+1.
  - Otherwise ovf=0; load partial remainder R (W+1 bits) = {0, dividend[2W-1:W]} and shift register Q = dividend[W-1:0]; count=W-1; next state is RUN.
- RUN, one step per cycle:
  - T = {R[W-1:0], Q[W-1]} - {0, D}, computed at W+1 bits.
  - If T is non-negative (no borrow): R = T and Q = {Q[W-2:0], 1}. Otherwise R = {R[W-1:0], Q[W-1]} and Q = {Q[W-2:0], 0}.
  - If count==0, go to DONE and load quotient=Q_next and remainder=R_next[W-1:0]. Otherwise decrement count.
- Latency: for a non-overflow start at edge k, RUN lasts W cycles (edges k+1..k+W), done is high in cycle k+W+1, and the core is back in IDLE after edge k+W+2. Overflow latency is 1 cycle.
- DONE: unconditional transition to IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored. No queuing, and dividend/divisor changes have no effect on the operation in flight.
- Back-to-back: start held high continuously is accepted in each IDLE cycle. Throughput is one divide per W+2 cycles.
- Outputs quotient, remainder and ovf keep the last result until the next accepted start. They are not cleared on the IDLE transition.
- Invariant, non-overflow case: quotient*divisor + remainder == dividend, with remainder < divisor.

Test Plan:
- Exact divide: reset pulse low, then start with dividend=16'h8480, divisor=8'hA0. Required: busy for 8 cycles, done at start edge+9, quotient=8'hD4, remainder=8'h00, ovf=0.
- Non-zero remainder: dividend=16'hFEFF, divisor=8'hFF -> quotient=8'hFF, remainder=8'hFE, ovf=0. Also dividend=16'h8485, divisor=8'hA0 -> quotient=8'hD4, remainder=8'h05.
- Divide-by-zero: dividend=16'h1234, divisor=8'h00 -> done one cycle after start, ovf=1, quotient=0, remainder=0, busy never high.
- Quotient overflow: dividend=16'hA000, divisor=8'hA0 -> ovf=1 at 1-cycle latency. Boundary case dividend=16'h9FFF, divisor=8'hA0 -> ovf=0, quotient=8'hFF, remainder=8'h9F.
- Mid-op events:
  - Pulse start and change dividend/divisor during RUN: the result is unaffected.
  - Assert reset=0 at RUN cycle 4: all outputs 0 immediately and no done pulse. After release, a new start (16'h00FF / 8'h01) gives quotient=8'hFF, remainder=0.
- Randomised self-check: 1000 random pairs with dividend[15:8] < divisor != 0, start held high continuously. Each done is checked against the invariant, and done spacing is exactly 10 cycles.

Source files
------------

// File: rtl/sdiv8.sv
// -----------------------------------------------------------------------------
// sdiv8 -- sequential unsigned restoring (shift-subtract) divider.
//
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per
// clock, producing a WIDTH-bit quotient and WIDTH-bit remainder. Intended to
// take a shift-add multiplier product directly as its dividend.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   asynchronous active-low reset
//   start      in   request, only sampled while idle
//   dividend   in   [2*WIDTH-1:0] unsigned dividend, captured on accepted start
//   divisor    in   [WIDTH-1:0]   unsigned divisor, captured on accepted start
//   busy       out  high while iterating (WIDTH cycles)
//   done       out  one-cycle completion pulse
//   ovf        out  result invalid (divide-by-zero or quotient overflow)
//   quotient   out  [WIDTH-1:0] result, held until the next accepted start
//   remainder  out  [WIDTH-1:0] result, held until the next accepted start
// -----------------------------------------------------------------------------
module sdiv8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;    // captured divisor
    // Partial remainder. It is always strictly less than the divisor between
    // steps, so its top (W+1-th) bit is identically zero and is not stored.
    logic [WIDTH-1:0] prem_q,  prem_d;
    logic [WIDTH-1:0] qsh_q,   qsh_d;    // dividend low half shifting out, quotient bits shifting in
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;

    // One restoring step: shift the next dividend bit into the partial
    // remainder (W+1 bits wide) and subtract the divisor if it fits.
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prem_step;
    logic [WIDTH-1:0] qsh_step;
    logic [WIDTH-1:0] dvd_hi;

    always_comb begin
        shifted   = {prem_q, qsh_q[WIDTH-1]};
        fits      = (shifted >= {1'b0, dvs_q});
        // When the divisor fits, the true difference is below the divisor and
        // therefore fits in WIDTH bits, so modulo-2^WIDTH subtraction is exact.
        diff      = shifted[WIDTH-1:0] - dvs_q;
        prem_step = fits ? diff : shifted[WIDTH-1:0];
        qsh_step  = {qsh_q[WIDTH-2:0], fits};
        dvd_hi    = dividend[2*WIDTH-1:WIDTH];
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qsh_d   = qsh_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    // A high half >= divisor means the quotient needs more
                    // than WIDTH bits; divisor==0 is caught by the same test
                    // but is spelled out for clarity.
                    if ((divisor == '0) || (dvd_hi >= divisor)) begin
                        ovf_d   = 1'b1;
                        quot_d  = '0;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        ovf_d   = 1'b0;
                        prem_d  = dvd_hi;
                        qsh_d   = dividend[WIDTH-1:0];
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                prem_d = prem_step;
                qsh_d  = qsh_step;
                if (cnt_q == '0) begin
                    quot_d  = qsh_step;
                    rem_d   = prem_step;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dvs_q   <= '0;
            prem_q  <= '0;
            qsh_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qsh_q   <= qsh_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign ovf       = ovf_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_sdiv8.sv
// -----------------------------------------------------------------------------
// tb_sdiv8 -- self-checking bench for sdiv8 (WIDTH=8).
// Directed vector table, hand-written mid-operation sequences, and a random
// back-to-back run checked against plain integer division.
// -----------------------------------------------------------------------------
module tb_sdiv8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  dividend;
    logic [7:0]   divisor;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [7:0]   quotient;
    logic [7:0]   remainder;

    int checks   = 0;
    int failures = 0;

    sdiv8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one divide from idle (caller is at a falling edge) and follow it
    // to completion. lat counts falling edges after the accepting clock edge.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output int lat, output int nbusy,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic o, output logic idle_after);
        lat   = -1;
        nbusy = 0;
        q     = '0;
        r     = '0;
        o     = 1'b0;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = n;
                q   = quotient;
                r   = remainder;
                o   = ovf;
                break;
            end
        end
        @(negedge clk);
        idle_after = !done && !busy;
    endtask

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        o;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    // Randomised back-to-back bookkeeping
    logic [15:0] exp_dvd_q[$];
    logic [7:0]  exp_dvs_q[$];

    task automatic present_random();
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
        b  = 8'($urandom_range(1, 255));
        hi = 8'($urandom_range(0, int'(b) - 1));
        lo = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) begin
            hi = b - 8'd1;
            lo = 8'hFF;
        end
        dividend = {hi, lo};
        divisor  = b;
        exp_dvd_q.push_back({hi, lo});
        exp_dvs_q.push_back(b);
    endtask

    initial begin
        int          lat, nbusy, exp_lat, exp_busy;
        logic [7:0]  q, r;
        logic        o, idle_after;
        int          n_done, presented, last_done;
        logic [15:0] a;
        logic [7:0]  b;
        logic [31:0] eq, er;

        vecs[0] = '{16'h8480, 8'hA0, 8'hD4, 8'h00, 1'b0};
        vecs[1] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0};
        vecs[2] = '{16'h8485, 8'hA0, 8'hD4, 8'h05, 1'b0};
        vecs[3] = '{16'h1234, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{16'hA000, 8'hA0, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{16'h9FFF, 8'hA0, 8'hFF, 8'h9F, 1'b0};
        vecs[6] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0};
        vecs[7] = '{16'h0000, 8'h07, 8'h00, 8'h00, 1'b0};
        vecs[8] = '{16'hFFFF, 8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[9] = '{16'h0064, 8'h03, 8'h21, 8'h01, 1'b0};

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < NV; i++) begin
            run_div(vecs[i].dvd, vecs[i].dvs, lat, nbusy, q, r, o, idle_after);
            exp_lat  = vecs[i].o ? 1 : W + 1;
            exp_busy = vecs[i].o ? 0 : W;
            check($sformatf("v%0d_latency", i), lat, exp_lat);
            check($sformatf("v%0d_busy_cycles", i), nbusy, exp_busy);
            check($sformatf("v%0d_quotient", i), q, vecs[i].q);
            check($sformatf("v%0d_remainder", i), r, vecs[i].r);
            check($sformatf("v%0d_ovf", i), o, vecs[i].o);
            check($sformatf("v%0d_done_pulse", i), idle_after, 1);
        end

        // ---------------- start pulse and input changes during RUN ----------------
        start    = 1'b1;
        dividend = 16'h8480;
        divisor  = 8'hA0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 3) begin
                start    = 1'b1;
                dividend = 16'hFFFF;
                divisor  = 8'h01;
            end
            if (n == 4) begin
                dividend = 16'h0000;
                divisor  = 8'h00;
            end
            if (done) begin
                lat = n;
                q = quotient;
                r = remainder;
                o = ovf;
                break;
            end
        end
        check("midrun_latency", lat, W + 1);
        check("midrun_quotient", q, 8'hD4);
        check("midrun_remainder", r, 8'h00);
        check("midrun_ovf", o, 0);
        @(negedge clk);

        // ---------------- reset during RUN ----------------
        start    = 1'b1;
        dividend = 16'h8485;
        divisor  = 8'hA0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ovf", ovf, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        reset = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("abort_no_activity", n_done, 0);
        run_div(16'h00FF, 8'h01, lat, nbusy, q, r, o, idle_after);
        check("post_abort_latency", lat, W + 1);
        check("post_abort_quotient", q, 8'hFF);
        check("post_abort_remainder", r, 8'h00);
        check("post_abort_ovf", o, 0);

        // ---------------- random, start held high ----------------
        n_done    = 0;
        presented = 1;
        last_done = -1;
        start     = 1'b1;
        present_random();
        for (int cyc = 1; cyc <= 1000 * (W + 2) + 40 && n_done < 1000; cyc++) begin
            @(negedge clk);
            if (done) begin
                check("rand_expect_pending", (exp_dvd_q.size() != 0), 1);
                if (exp_dvd_q.size() != 0) begin
                    a  = exp_dvd_q.pop_front();
                    b  = exp_dvs_q.pop_front();
                    eq = 32'(a) / 32'(b);
                    er = 32'(a) % 32'(b);
                    check($sformatf("rand%0d_quotient(%h/%h)", n_done, a, b), quotient, eq);
                    check($sformatf("rand%0d_remainder(%h/%h)", n_done, a, b), remainder, er);
                    check($sformatf("rand%0d_ovf", n_done), ovf, 0);
                    check($sformatf("rand%0d_invariant", n_done),
                          32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                end
                if (last_done >= 0)
                    check($sformatf("rand%0d_spacing", n_done), cyc - last_done, W + 2);
                last_done = cyc;
                n_done++;
                if (presented < 1000) begin
                    present_random();
                    presented++;
                end
            end
        end
        start = 1'b0;
        check("rand_done_count", n_done, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
